// File: rtl/pixel_packer_pkg.sv
// Shared widths, FIFO entry layout and frame-state encoding for the pixel packer.
package pixel_packer_pkg;

  localparam int unsigned PIX_W        = 16;
  localparam int unsigned WORD_W       = 64;
  localparam int unsigned PIX_PER_WORD = 4;
  localparam int unsigned SLOT_W       = 2;
  localparam int unsigned CNT_W        = 16;
  localparam int unsigned SOF_BIT      = 64;
  localparam int unsigned EOL_BIT      = 65;
  localparam int unsigned ENTRY_W      = 66;

  // One FIFO entry: eol at bit 65, sof at bit 64, packed pixels below
  typedef struct packed {
    logic              eol;
    logic              sof;
    logic [WORD_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DROP = 2'd1,
    ST_DONE = 2'd2
  } frame_state_e;

endpackage

// File: rtl/pixel_packer_if.sv
// Packed-word stream from the pixel packer to the DDR writer.
interface pixel_packer_if;
  import pixel_packer_pkg::*;

  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_sof;
  logic              m_eol;

  modport master (output m_data, output m_valid, output m_sof, output m_eol, input m_ready);
  modport slave  (input m_data, input m_valid, input m_sof, input m_eol, output m_ready);

endinterface

// File: rtl/pixel_packer_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with registered flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 66,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             wr_ok;
  logic             rd_ok;

  // A write while full is accepted only when the head leaves in the same cycle
  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  // Head entry falls through; forced to zero while empty
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Occupancy update
  always_comb begin
    count_nxt = count;
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CW'(DEPTH));
    end
  end

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pixel_packer.sv
// Packs RGB565 pixels four to a 64-bit word, tags sof/eol, buffers in a FIFO
// and drops the rest of a frame once the FIFO overflows.
module pixel_packer
  import pixel_packer_pkg::*;
#(
  parameter int unsigned PIX_PER_LINE = 320,
  parameter int unsigned LINES        = 240,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic               p_clock,
  input  logic               rst_n,
  input  logic [PIX_W-1:0]   pixel_data,
  input  logic               pixel_valid,
  input  logic               frame_done,
  pixel_packer_if.master     m,
  output logic               overflow,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int unsigned XW     = (PIX_PER_LINE > 1) ? $clog2(PIX_PER_LINE) : 1;
  localparam int unsigned YW     = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int unsigned LANE_W = PIX_W * (PIX_PER_WORD - 1);

  frame_state_e      state;
  frame_state_e      state_nxt;
  logic [SLOT_W-1:0] slot;
  logic [LANE_W-1:0] lanes;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic              sof_pending;

  logic   drop_frame_c;
  logic   frame_open_c;
  logic   accept_c;
  logic   word_done_c;
  logic   last_x_c;
  logic   last_y_c;
  logic   frame_end_c;
  logic   pop_c;
  logic   drop_word_c;
  logic   push_c;
  entry_t push_entry_c;
  entry_t head_entry;
  logic   fifo_full;
  logic   fifo_empty;

  // Frame state register
  always_ff @(posedge p_clock) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Frame state transitions; frame_done always restarts a clean frame
  always_comb begin
    state_nxt = state;
    if (frame_done) begin
      state_nxt = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (frame_end_c)      state_nxt = ST_DONE;
          else if (drop_word_c) state_nxt = ST_DROP;
        end
        ST_DROP: begin
          if (frame_end_c) state_nxt = ST_DONE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Frame state decode
  always_comb begin
    drop_frame_c = 1'b0;
    frame_open_c = 1'b1;
    case (state)
      ST_DROP: drop_frame_c = 1'b1;
      ST_DONE: frame_open_c = 1'b0;
      default: ;
    endcase
  end

  // Word completion, tagging and push/drop decision
  always_comb begin
    accept_c          = pixel_valid && !frame_done && frame_open_c;
    word_done_c       = accept_c && (slot == SLOT_W'(PIX_PER_WORD - 1));
    last_x_c          = (x == XW'(PIX_PER_LINE - 1));
    last_y_c          = (y == YW'(LINES - 1));
    frame_end_c       = word_done_c && last_x_c && last_y_c;
    pop_c             = !fifo_empty && m.m_ready;
    drop_word_c       = word_done_c && (drop_frame_c || (fifo_full && !pop_c));
    push_c            = word_done_c && !drop_word_c;
    push_entry_c.eol  = last_x_c;
    push_entry_c.sof  = sof_pending;
    push_entry_c.data = {pixel_data, lanes};
  end

  // Packer slot, lane buffer and pixel position
  always_ff @(posedge p_clock) begin
    if (!rst_n) begin
      slot  <= '0;
      lanes <= '0;
      x     <= '0;
      y     <= '0;
    end else if (frame_done) begin
      slot <= '0;
      x    <= '0;
      y    <= '0;
    end else if (accept_c) begin
      slot <= slot + SLOT_W'(1);
      if (!word_done_c) lanes[PIX_W*int'(slot) +: PIX_W] <= pixel_data;
      x <= last_x_c ? '0 : x + XW'(1);
      if (last_x_c) y <= last_y_c ? '0 : y + YW'(1);
    end
  end

  // SOF tagging and drop/frame statistics
  always_ff @(posedge p_clock) begin
    if (!rst_n) begin
      sof_pending <= 1'b0;
      overflow    <= 1'b0;
      drop_cnt    <= '0;
      frame_cnt   <= '0;
    end else begin
      if (frame_done)  sof_pending <= 1'b1;
      else if (push_c) sof_pending <= 1'b0;
      if (drop_word_c) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (push_c && frame_end_c) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (p_clock),
    .rst_n   (rst_n),
    .wr_en   (push_c),
    .wr_data (push_entry_c),
    .full    (fifo_full),
    .rd_en   (m.m_ready),
    .rd_data (head_entry),
    .empty   (fifo_empty)
  );

  assign m.m_valid = !fifo_empty;
  assign m.m_data  = head_entry.data;
  assign m.m_sof   = head_entry.sof;
  assign m.m_eol   = head_entry.eol;

endmodule
